// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding selects, load-use stalls, memory-wait and branch
//               flush sequencing for the 5-stage Thumb-subset pipeline.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_id_rs_a,
  input  logic       i_id_rs_a_en,
  input  logic [3:0] i_id_rs_b,
  input  logic       i_id_rs_b_en,
  input  logic [3:0] i_ex_rd,
  input  logic       i_ex_rd_en,
  input  logic       i_ex_is_load,
  input  logic [3:0] i_mem_rd,
  input  logic       i_mem_rd_en,
  input  logic [3:0] i_wb_rd,
  input  logic       i_wb_rd_en,
  input  logic       i_mem_req,
  input  logic       i_mem_ack,
  input  logic       i_branch_taken,
  output logic       o_stall_front,
  output logic       o_stall_back,
  output logic       o_bubble_ex,
  output logic       o_flush_id,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH2   = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  // Newest producer (MEM) has priority over the older one (WB).
  function automatic logic [1:0] fwd_sel(input logic [3:0] rs, input logic rs_en,
                                         input logic [3:0] mrd, input logic mrd_en,
                                         input logic [3:0] wrd, input logic wrd_en);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs_en && mrd_en && (rs == mrd))      sel = 2'b01;
    else if (rs_en && wrd_en && (rs == wrd)) sel = 2'b10;
    return sel;
  endfunction

  logic w_load_use;
  logic w_wait_start;

  assign w_load_use = i_ex_rd_en && i_ex_is_load &&
                      ((i_id_rs_a_en && (i_id_rs_a == i_ex_rd)) ||
                       (i_id_rs_b_en && (i_id_rs_b == i_ex_rd)));
  assign w_wait_start = i_mem_req && !i_mem_ack;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    o_stall_front = 1'b0;
    o_stall_back  = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_id    = 1'b0;
    o_timeout_err = 1'b0;
    o_fwd_a       = fwd_sel(i_id_rs_a, i_id_rs_a_en, i_mem_rd, i_mem_rd_en, i_wb_rd, i_wb_rd_en);
    o_fwd_b       = fwd_sel(i_id_rs_b, i_id_rs_b_en, i_mem_rd, i_mem_rd_en, i_wb_rd, i_wb_rd_en);

    case (state_q)
      S_IDLE: begin
        // A memory stall holds EX, so a branch seen now is deferred to the ack cycle.
        if (w_wait_start) begin
          o_stall_front = 1'b1;
          o_stall_back  = 1'b1;
          cnt_d         = C_ONE;
          pend_d        = i_branch_taken;
          state_d       = S_MEM_WAIT;
        end else if (i_branch_taken) begin
          o_flush_id    = 1'b1;
          o_bubble_ex   = 1'b1;
          state_d       = S_FLUSH2;
        end else if (w_load_use) begin
          o_stall_front = 1'b1;
          o_bubble_ex   = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (i_mem_ack) begin
          cnt_d  = '0;
          pend_d = 1'b0;
          if (pend_q || i_branch_taken) begin
            o_flush_id  = 1'b1;
            o_bubble_ex = 1'b1;
            state_d     = S_FLUSH2;
          end else begin
            state_d     = S_IDLE;
          end
        end else begin
          o_stall_front = 1'b1;
          o_stall_back  = 1'b1;
          pend_d        = pend_q || i_branch_taken;
          if (cnt_q == C_TIMEOUT) begin
            state_d = S_ERR;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d   = cnt_q + C_ONE;
          end
        end
      end
      S_FLUSH2: begin
        o_flush_id = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        o_stall_front = 1'b1;
        o_stall_back  = 1'b1;
        o_timeout_err = 1'b1;
        o_fwd_a       = 2'b00;
        o_fwd_b       = 2'b00;
      end
    endcase

    if (rst) begin
      o_stall_front = 1'b0;
      o_stall_back  = 1'b0;
      o_bubble_ex   = 1'b0;
      o_flush_id    = 1'b0;
      o_timeout_err = 1'b0;
      o_fwd_a       = 2'b00;
      o_fwd_b       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed plus random stimulus against a cycle-level
//                  reference model of the hazard rules.
// Revision       : 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rs_a, rs_b, ex_rd, mem_rd, wb_rd;
  logic       rs_a_en, rs_b_en, ex_rd_en, ex_is_load, mem_rd_en, wb_rd_en;
  logic       mem_req, mem_ack, br;
  logic       stall_front, stall_back, bubble_ex, flush_id, timeout_err;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_id_rs_a      (rs_a),
    .i_id_rs_a_en   (rs_a_en),
    .i_id_rs_b      (rs_b),
    .i_id_rs_b_en   (rs_b_en),
    .i_ex_rd        (ex_rd),
    .i_ex_rd_en     (ex_rd_en),
    .i_ex_is_load   (ex_is_load),
    .i_mem_rd       (mem_rd),
    .i_mem_rd_en    (mem_rd_en),
    .i_wb_rd        (wb_rd),
    .i_wb_rd_en     (wb_rd_en),
    .i_mem_req      (mem_req),
    .i_mem_ack      (mem_ack),
    .i_branch_taken (br),
    .o_stall_front  (stall_front),
    .o_stall_back   (stall_back),
    .o_bubble_ex    (bubble_ex),
    .o_flush_id     (flush_id),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_timeout_err  (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycles already waited (0 = not waiting), deferred flush,
  // second flush cycle owed, and the sticky error.
  int m_wait = 0;
  bit m_pend = 0;
  bit m_fl2  = 0;
  bit m_err  = 0;

  function automatic logic [1:0] ref_fwd(input logic [3:0] rs, input logic en);
    if (en && mem_rd_en && rs == mem_rd) return 2'b01;
    if (en && wb_rd_en && rs == wb_rd)   return 2'b10;
    return 2'b00;
  endfunction

  task automatic cyc(input string tag);
    logic [8:0] obs, exp;
    logic       sf, sb, bub, fl, e, lu;
    logic [1:0] fa, fb;
    #1;
    {sf, sb, bub, fl, e} = '0;
    fa = 2'b00;
    fb = 2'b00;
    lu = ex_rd_en && ex_is_load &&
         ((rs_a_en && rs_a == ex_rd) || (rs_b_en && rs_b == ex_rd));
    if (rst) begin
      m_wait = 0; m_pend = 0; m_fl2 = 0; m_err = 0;
    end else if (m_err) begin
      sf = 1; sb = 1; e = 1;
    end else begin
      fa = ref_fwd(rs_a, rs_a_en);
      fb = ref_fwd(rs_b, rs_b_en);
      if (m_wait > 0) begin
        if (mem_ack) begin
          if (m_pend || br) begin fl = 1; bub = 1; m_fl2 = 1; end
          m_wait = 0; m_pend = 0;
        end else begin
          sf = 1; sb = 1;
          m_pend = m_pend || br;
          if (m_wait >= TMO) begin m_err = 1; m_wait = 0; m_pend = 0; end
          else m_wait++;
        end
      end else if (m_fl2) begin
        fl = 1; m_fl2 = 0;
      end else if (mem_req && !mem_ack) begin
        sf = 1; sb = 1; m_wait = 1; m_pend = br;
      end else if (br) begin
        fl = 1; bub = 1; m_fl2 = 1;
      end else if (lu) begin
        sf = 1; bub = 1;
      end
    end
    exp = {sf, sb, bub, fl, fa, fb, e};
    obs = {stall_front, stall_back, bubble_ex, flush_id, fwd_a, fwd_b, timeout_err};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed {sf,sb,bub,fl,fa,fb,err}=%b required %b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic clr();
    {rs_a, rs_b, ex_rd, mem_rd, wb_rd} = '0;
    {rs_a_en, rs_b_en, ex_rd_en, ex_is_load, mem_rd_en, wb_rd_en} = '0;
    {mem_req, mem_ack, br} = '0;
  endtask

  task automatic rnd();
    rs_a       = 4'($urandom_range(0, 7));
    rs_b       = 4'($urandom_range(0, 7));
    ex_rd      = 4'($urandom_range(0, 7));
    mem_rd     = 4'($urandom_range(0, 7));
    wb_rd      = 4'($urandom_range(0, 7));
    rs_a_en    = ($urandom_range(0, 3) != 0);
    rs_b_en    = ($urandom_range(0, 3) != 0);
    ex_rd_en   = ($urandom_range(0, 1) != 0);
    ex_is_load = ($urandom_range(0, 1) != 0);
    mem_rd_en  = ($urandom_range(0, 1) != 0);
    wb_rd_en   = ($urandom_range(0, 1) != 0);
    mem_req    = ($urandom_range(0, 3) == 0);
    mem_ack    = ($urandom_range(0, 2) == 0);
    br         = ($urandom_range(0, 7) == 0);
    rst        = ($urandom_range(0, 99) == 0) || (m_err && $urandom_range(0, 3) == 0);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    // Reset must mask outputs even with matching operands present.
    rs_a = 4'd2; rs_a_en = 1; mem_rd = 4'd2; mem_rd_en = 1; mem_req = 1; br = 1;
    cyc("reset_0");
    cyc("reset_1");
    rst = 1'b0;

    clr(); ex_rd = 4'd2; ex_rd_en = 1; ex_is_load = 1; rs_a = 4'd2; rs_a_en = 1;
    cyc("load_use");
    clr(); mem_rd = 4'd2; mem_rd_en = 1; rs_a = 4'd2; rs_a_en = 1;
    cyc("load_fwd");

    clr(); mem_rd = 4'd3; mem_rd_en = 1; wb_rd = 4'd3; wb_rd_en = 1; rs_b = 4'd3; rs_b_en = 1;
    cyc("fwd_mem_wins");
    mem_rd_en = 0;   cyc("fwd_wb");
    rs_b_en = 0;     cyc("fwd_none");
    clr(); rs_a = 4'd13; rs_a_en = 1; wb_rd = 4'd13; wb_rd_en = 1;
    cyc("fwd_sp");

    clr(); mem_req = 1;
    cyc("wait_start"); cyc("wait_1"); cyc("wait_2");
    mem_ack = 1;     cyc("wait_ack");
    clr();           cyc("after_ack");
    mem_req = 1; mem_ack = 1; cyc("zero_wait");
    clr();           cyc("zero_wait_next");

    mem_req = 1;     cyc("bw_start");
    br = 1;          cyc("bw_branch");
    br = 0;          cyc("bw_wait");
    mem_ack = 1;     cyc("bw_ack_flush");
    clr();           cyc("bw_flush2");
    cyc("bw_idle");

    ex_rd = 4'd5; ex_rd_en = 1; ex_is_load = 1; rs_a = 4'd5; rs_a_en = 1; br = 1;
    cyc("br_over_lu");
    clr();           cyc("br_lu_flush2");
    cyc("br_lu_idle");

    mem_req = 1;
    for (int i = 0; i < TMO + 1; i++) cyc("timeout_wait");
    for (int i = 0; i < 3; i++) cyc("err_hold");
    rst = 1;         cyc("err_reset");
    rst = 0; clr();  cyc("post_reset");

    for (int i = 0; i < 3000; i++) begin
      rnd();
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
